uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter on the core's data-memory port, alongside data RAM. Decodes stores and loads from the datapath's dmem interface (address, write data, write enable). Buffers bytes in a FIFO and serialises them as 8N1 frames on `tx`. Returns status combinationally on the read path, as required by the single-cycle load timing.

## Interface

Parameters:
- `XLEN`, 32: data/address width.
- `BASE_ADDR`, 32'h0001_0000: base of the 16-byte register window; bits [3:0] must be zero.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  XLEN  dmem byte address from the datapath.
- `wdata`  in  XLEN  dmem store data, already lane-aligned.
- `we`  in  1  dmem write enable.
- `hit`  out  1  combinational; `addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]`.
- `rdata`  out  XLEN  combinational read data; 0 when `hit`=0.
- `tx`  out  1  serial output, registered, idle high.

## Operation

Register map, selected by `addr[3:2]` when `hit`=1:
- 0x0 TXDATA
  - Write: push `wdata[7:0]`.
  - Read: returns 0.
- 0x4 STATUS
  - Read:
    - bit0 = full.
    - bit1 = idle (FIFO empty and FSM in IDLE).
    - bit2 = overflow (sticky).
    - bits[8 +: $clog2(FIFO_DEPTH)+1] = FIFO count.
    - All other bits 0.
  - Write: bit2=1 clears overflow (write-1-to-clear); other bits ignored.
- 0x8, 0xC: read 0, writes ignored.
- `addr[1:0]` is ignored. A byte store to base+0 lands in `wdata[7:0]`.

Push rule:
- A push is `hit & we & offset==0`.
- The push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle (count unchanged).
- Otherwise the byte is dropped and overflow is set.
- If an overflow set and a W1C clear fall in the same cycle, set wins. This cannot occur from a single store; it is listed for completeness.

FIFO:
- Circular buffer with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
- The count register is one bit wider than the pointers.

TX FSM, states IDLE, START, DATA, STOP:
- IDLE: `tx`=1. If count > 0, pop the head into an 8-bit shift register, clear the bit counter, and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx`=shift[0]. After each CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Data is sent LSB first.

Baud counter:
- Counts down from CLKS_PER_BIT-1.
- Reloads on every state entry and at each bit boundary.
- Width is $clog2(CLKS_PER_BIT).

## Timing

- Reset values:
  - `tx`=1; FSM = IDLE.
  - FIFO pointers and count = 0.
  - overflow = 0; shift register = 0.
  - `rdata`/`hit` are combinational and follow `addr`.
- Reset mid-frame aborts the frame: `tx` is 1 after the reset edge and the FIFO contents are discarded.
- Read latency is 0 cycles: `rdata` reflects register state in the same cycle as `addr`.
- Write visibility: a push sampled at edge E0 appears in STATUS.count after E0.
- Frame timing, for a push at E0 into an empty FIFO with the FSM in IDLE:
  - Pop occurs in the cycle after E0.
  - `tx` goes low at E0+1 (registered START).
  - `tx` stays low for exactly CLKS_PER_BIT cycles.
  - Stop bit ends at E0+1+10·CLKS_PER_BIT.
- Back-to-back frames: STOP → IDLE → pop → START. This gives exactly one extra idle-high cycle between frames, so the frame pitch is 10·CLKS_PER_BIT+1 cycles.
- STATUS.idle returns to 1 on the cycle after the final STOP bit completes, when the FIFO is empty.

## Test plan

- **Reset:** assert `reset` 2 cycles, CLKS_PER_BIT=4 → `tx`=1; STATUS read at 0x0001_0004 = 0x0000_0002.
- **Single byte:** store 0xA5 to 0x0001_0000 → `tx` low at E0+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high. STATUS.idle=1 at E0+42.
- **Fill and overflow:** 9 stores 0x00..0x08 within 9 consecutive cycles while the first frame is in progress → the first byte is popped, so count peaks at 8 with no overflow. A 10th store → overflow=1, count=8. Write STATUS 0x4 → overflow=0.
- **Simultaneous push/pop at full:** count=8 and the FSM enters IDLE (pop) in the same cycle as a push → byte accepted, count stays 8, overflow stays 0.
- **Reset mid-frame:** store 0x55 and 0x66, assert `reset` during DATA bit 3 → `tx`=1 next cycle, count=0, no further frames.
- **Decode:** store to 0x0001_0010 and 0x0000_0000 → `hit`=0, no push. Read 0x0001_0008 → `rdata`=0, `hit`=1.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Purpose: memory-mapped 8N1 UART transmitter on the dmem port, with a TX FIFO and a STATUS register.
// Latency: reads are combinational (0 cycles); a pushed byte starts its start bit one cycle after the push edge.
// Backpressure: none on the bus; a store into a full FIFO (with no pop that cycle) is dropped and sets sticky overflow.
//
// Ports:
//   clk, reset  - clock; synchronous active-high reset (aborts any frame, empties the FIFO)
//   addr        - dmem byte address; [XLEN-1:4] selects the window, [3:2] the register, [1:0] ignored
//   wdata, we   - dmem store data (lane-aligned) and write enable
//   hit         - combinational: address falls in this block's 16-byte window
//   rdata       - combinational read data, 0 when not hit
//   tx          - registered serial output, idle high, LSB first
//
// Register map (offset = addr[3:2] * 4):
//   0x0 TXDATA  W: push wdata[7:0]        R: 0
//   0x4 STATUS  R: [0] full, [1] idle, [2] overflow, [8 +: PW+1] count
//               W: bit2 = 1 clears overflow
//   0x8, 0xC    R: 0, writes ignored

module uart_tx_mmio #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   BASE_ADDR    = 32'h0001_0000,
    parameter int                CLKS_PER_BIT = 16,
    parameter int                FIFO_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            we,
    output logic            hit,
    output logic [XLEN-1:0] rdata,
    output logic            tx
);

    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]     DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [1:0] offset;
    logic       push_req;
    logic       ovf_clr;

    assign hit      = (addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign offset   = addr[3:2];
    assign push_req = hit & we & (offset == OFF_TXDATA);
    assign ovf_clr  = hit & we & (offset == OFF_STATUS) & wdata[2];

    // Byte-lane and sub-word address bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[XLEN-1:8]};

    // ------------------------------------------------------------------
    // TX FIFO state
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          push_ok;
    logic          ovf_set;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);

    // A pop in the same cycle frees the slot the push needs, so a full
    // FIFO still accepts the byte and the count stays put.
    assign push_ok = push_req & (~fifo_full | pop);
    assign ovf_set = push_req & ~push_ok;

    // ------------------------------------------------------------------
    // TX FSM state
    // ------------------------------------------------------------------
    tx_state_t         state;
    tx_state_t         state_next;
    logic [BAUD_W-1:0] baud;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_next;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic              tx_next;

    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_mem[rd_ptr];
                    bit_idx_next = 3'd0;
                    baud_next    = BAUD_RELOAD;
                    state_next   = ST_START;
                end
            end
            ST_START: begin
                if (baud == '0) begin
                    baud_next  = BAUD_RELOAD;
                    state_next = ST_DATA;
                end else begin
                    baud_next = baud - 1'b1;
                end
            end
            ST_DATA: begin
                if (baud == '0) begin
                    baud_next    = BAUD_RELOAD;
                    shift_next   = {1'b0, shift[7:1]};
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    baud_next = baud - 1'b1;
                end
            end
            ST_STOP: begin
                if (baud == '0) begin
                    baud_next  = BAUD_RELOAD;
                    state_next = ST_IDLE;
                end else begin
                    baud_next = baud - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // tx is registered from the next state so the line changes on the
        // same edge the FSM enters a state (start bit begins at pop edge).
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, count and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set takes priority over a clear landing in the same cycle.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is not reset; the pointers define which entries are valid.
    // On a push+pop at full both pointers address the same slot: the pop
    // reads the old byte combinationally before this write lands.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic tx_idle;
    assign tx_idle = fifo_empty & (state == ST_IDLE);

    always_comb begin
        rdata = '0;
        if (hit && (offset == OFF_STATUS)) begin
            rdata[0]      = fifo_full;
            rdata[1]      = tx_idle;
            rdata[2]      = overflow;
            rdata[8 +: CW] = count;
        end
    end

endmodule
